exp_lut_rr_sched: RTL

// - Round-robin scheduler sharing one integer-exponent LUT (5b signed int in, 16b {12.4} out) among NREQ requesters.
// - Sits between the pipelined 8-bit-mul datapath lanes and the single exp LUT instance.
// - Arbitrates, registers the winner, looks it up, returns result + requester tag on a valid/ready output.

---
 rtl/exp_lut_rr_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exp_lut_rr_sched.sv
// exp_lut_rr_sched
// Shares one integer-exponent LUT (5b signed in, 16b {12.4} out) among NREQ
// requesters. Stage 1 registers the arbitration winner; stage 2 is the output
// register holding the looked-up value and the owner tag on a valid/ready port.
// Build option: define EXP_LUT_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no pointer register); default build is round-robin.
module exp_lut_rr_sched #(
   parameter int NREQ  = 4,
   parameter int TAG_W = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*5-1:0]   req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic                o_valid,
   input  logic                o_ready,
   output logic [15:0]         o_data,
   output logic [TAG_W-1:0]    o_tag
);

   // Integer exp table; must stay identical to the shared LUT instance.
   function automatic logic [15:0] exp_lut(input logic [4:0] x);
      logic [15:0] y;
      case (x)
         5'b11110: y = 16'd3;      // -2
         5'b11111: y = 16'd6;      // -1
         5'd0:     y = 16'd16;
         5'd1:     y = 16'd44;
         5'd2:     y = 16'd119;
         5'd3:     y = 16'd322;
         5'd4:     y = 16'd874;
         5'd5:     y = 16'd2375;
         5'd6:     y = 16'd6455;
         5'd7:     y = 16'd17547;
         5'd8:     y = 16'd32767;  // saturated
         default:  y = 16'd1;
      endcase
      return y;
   endfunction

   logic             s1_valid_r;
   logic [4:0]       s1_data_r;
   logic [TAG_W-1:0] s1_tag_r;
   logic             adv2_s;
   logic             adv1_s;
   logic             hit_s;
   logic             accept_s;
   logic [TAG_W-1:0] grant_s;
   logic [4:0]       grant_data_s;

   // Output register can load when empty or being drained; S1 when it empties into S2.
   assign adv2_s   = !o_valid || o_ready;
   assign adv1_s   = !s1_valid_r || adv2_s;
   assign accept_s = hit_s && adv1_s && rst_n;

`ifdef EXP_LUT_SCHED_FIXED_PRIO_EN
   // Fixed-priority search: the lowest-index valid requester wins.
   always_comb begin
      hit_s        = 1'b0;
      grant_s      = '0;
      grant_data_s = 5'd0;
      for (int k = 0; k < NREQ; k++) begin
         if (!hit_s && req_valid[k]) begin
            hit_s        = 1'b1;
            grant_s      = TAG_W'(k);
            grant_data_s = req_data[k*5 +: 5];
         end else begin
            hit_s = hit_s;
         end
      end
   end
`else
   logic [TAG_W-1:0] ptr_r;

   // Round-robin search beginning one past the last accepted requester, wrapping.
   always_comb begin
      int idx;
      hit_s        = 1'b0;
      grant_s      = '0;
      grant_data_s = 5'd0;
      idx          = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_r) + k) % NREQ;
         if (!hit_s && req_valid[idx]) begin
            hit_s        = 1'b1;
            grant_s      = TAG_W'(idx);
            grant_data_s = req_data[idx*5 +: 5];
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Pointer remembers the most recent accept; resets so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= TAG_W'(NREQ - 1);
      end else if (accept_s) begin
         ptr_r <= grant_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`endif

   // Only the granted requester sees ready, and only when S1 can take an entry.
   always_comb begin
      req_ready = '0;
      if (accept_s) begin
         req_ready[grant_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Stage 1: capture the accepted request, drain into S2, or hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= 5'd0;
         s1_tag_r   <= '0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_data_r  <= grant_data_s;
         s1_tag_r   <= grant_s;
      end else if (adv2_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Stage 2: look up S1 and present result; frozen while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_data  <= 16'd0;
         o_tag   <= '0;
      end else if (adv2_s) begin
         o_valid <= s1_valid_r;
         o_data  <= exp_lut(s1_data_r);
         o_tag   <= s1_tag_r;
      end else begin
         o_valid <= o_valid;
      end
   end

endmodule
